// File: rtl/call_stack.sv
`default_nettype none
// ============================================================================
// Module   : call_stack
// Purpose  : Hardware return-address stack (circular buffer) with sticky
//            overflow/underflow flags. Optional macro CALL_STACK_WRAP_EN makes
//            a push while full overwrite the oldest entry instead of dropping.
// Revision : 1.0 - initial release
// ============================================================================
module call_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic                       clr_err,
  output logic [ADDR_W-1:0]          top_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = $clog2(DEPTH+1);
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_TOP0  = c_PTR_W'(DEPTH-1);
  localparam logic [c_PTR_W-1:0] c_ONE   = c_PTR_W'(1);

  logic [ADDR_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_top;
  logic [c_CNT_W-1:0] r_count;
  logic               r_ovf;
  logic               r_unf;

  logic               w_empty;
  logic               w_full;
  logic               w_replace;
  logic               w_push_only;
  logic               w_pop_only;
  logic               w_adv;
  logic               w_inc;
  logic               w_dec;
  logic               w_ovf_evt;
  logic               w_unf_evt;
  logic               w_wr;
  logic [c_PTR_W-1:0] w_wr_idx;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_FULL);

  // push+pop on an empty stack degenerates to a plain push
  assign w_replace   = push & pop & ~w_empty;
  assign w_push_only = push & (~pop | w_empty);
  assign w_pop_only  = pop & ~push;

  assign w_inc       = w_push_only & ~w_full;
  assign w_dec       = w_pop_only & ~w_empty;
  assign w_ovf_evt   = w_push_only & w_full;
  assign w_unf_evt   = w_pop_only & w_empty;

`ifdef CALL_STACK_WRAP_EN
  assign w_adv       = w_push_only;
`else
  assign w_adv       = w_inc;
`endif

  assign w_wr        = w_adv | w_replace;
  assign w_wr_idx    = w_replace ? r_top : (r_top + c_ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_top   <= c_TOP0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_adv) begin
        r_top <= r_top + c_ONE;
      end else if (w_dec) begin
        r_top <= r_top - c_ONE;
      end

      if (w_inc) begin
        r_count <= r_count + 1'b1;
      end else if (w_dec) begin
        r_count <= r_count - 1'b1;
      end

      // an error event in the same cycle wins over the clear
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end

      if (w_unf_evt) begin
        r_unf <= 1'b1;
      end else if (clr_err) begin
        r_unf <= 1'b0;
      end
    end
  end

  // Storage is intentionally unreset; stale contents are masked by w_empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_wr_idx] <= push_addr;
    end
  end

  assign top_addr  = w_empty ? '0 : r_mem[r_top];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule
`default_nettype wire
